// File: rtl/blink_pkg.sv
// Shared types and elaboration-time helpers for the LED blink scheduler
// and its tick prescaler.
package blink_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Bits needed to hold values 0..value-1.
  function automatic int CeilLog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  function automatic int DivValue(input int ref_hz, input int tick_hz);
    return ref_hz / tick_hz;
  endfunction

endpackage

// File: rtl/blink_scheduler_tick_gen.sv
// Free-running prescaler producing a one-cycle enable every DIV clocks;
// clear restarts the count so a new phase begins on a full tick period.
module tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk_FPGA,
  input  logic reset,
  input  logic clear,
  output logic tick
);
  import blink_pkg::*;

  localparam int CW = (CeilLog2(DIV) < 1) ? 1 : CeilLog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt + CW'(1);
    if (clear || cnt == LAST) cnt_next = '0;
  end

  // tick is registered from the next count so it is high exactly while cnt == LAST.
  always_ff @(posedge clk_FPGA) begin
    if (reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= cnt_next;
      tick <= (cnt_next == LAST);
    end
  end

endmodule

// File: rtl/blink_scheduler.sv
// LED blink sequencer: on/off phases measured in prescaler ticks, repeated
// blink_count times (0 = until stop), with registered outputs.
module blink_scheduler
  import blink_pkg::*;
#(
  parameter int REFERENCE_CLOCK = 50_000_000,
  parameter int TICK_HZ         = 1_000,
  parameter int TIME_W          = 16,
  parameter int COUNT_W         = 8
) (
  input  logic               clk_FPGA,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic [TIME_W-1:0]  on_time,
  input  logic [TIME_W-1:0]  off_time,
  input  logic [COUNT_W-1:0] blink_count,
  output logic               led_out,
  output logic               busy,
  output logic               done,
  output logic               tick,
  output state_t             state_dbg
);

  localparam int DIV = DivValue(REFERENCE_CLOCK, TICK_HZ);

  state_t             state, state_next;
  logic [TIME_W-1:0]  on_reg, off_reg;
  logic [COUNT_W-1:0] cnt_reg;
  logic [TIME_W-1:0]  dur, dur_next;
  logic [COUNT_W-1:0] rem, rem_next;
  logic [TIME_W-1:0]  on_last, off_last;
  logic               start_ok;

  // start is sampled as a level only in IDLE; stop has priority and is only
  // meaningful while busy, so a start/stop pair in IDLE does nothing.
  assign start_ok  = (state == IDLE) && start && !stop;
  assign on_last   = (on_reg  == '0) ? '0 : on_reg  - TIME_W'(1);
  assign off_last  = (off_reg == '0) ? '0 : off_reg - TIME_W'(1);
  assign state_dbg = state;

  tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk_FPGA (clk_FPGA),
    .reset    (reset),
    .clear    (start_ok),
    .tick     (tick)
  );

  always_comb begin
    state_next = state;
    dur_next   = dur;
    rem_next   = rem;
    case (state)
      IDLE: begin
        if (start_ok) begin
          state_next = ON;
          dur_next   = '0;
          rem_next   = '0;
        end
      end
      ON: begin
        if (stop) begin
          state_next = IDLE;
          dur_next   = '0;
          rem_next   = '0;
        end else if (tick) begin
          if (dur == on_last) begin
            state_next = OFF;
            dur_next   = '0;
          end else begin
            dur_next = dur + TIME_W'(1);
          end
        end
      end
      OFF: begin
        if (stop) begin
          state_next = IDLE;
          dur_next   = '0;
          rem_next   = '0;
        end else if (tick) begin
          if (dur == off_last) begin
            dur_next = '0;
            if (cnt_reg != '0 && rem == cnt_reg - COUNT_W'(1)) begin
              state_next = DONE;
              rem_next   = '0;
            end else begin
              state_next = ON;
              // Endless mode never consults rem, so hold it rather than wrap.
              if (cnt_reg != '0) rem_next = rem + COUNT_W'(1);
            end
          end else begin
            dur_next = dur + TIME_W'(1);
          end
        end
      end
      DONE: state_next = IDLE;
      default: begin
        state_next = IDLE;
        dur_next   = '0;
        rem_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_FPGA) begin
    if (reset) begin
      state   <= IDLE;
      on_reg  <= '0;
      off_reg <= '0;
      cnt_reg <= '0;
      dur     <= '0;
      rem     <= '0;
      led_out <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state <= state_next;
      dur   <= dur_next;
      rem   <= rem_next;
      if (start_ok) begin
        on_reg  <= on_time;
        off_reg <= off_time;
        cnt_reg <= blink_count;
      end
      led_out <= (state_next == ON);
      busy    <= (state_next == ON) || (state_next == OFF);
      done    <= (state_next == DONE);
    end
  end

endmodule

// File: tb/tb_blink_scheduler.sv
// Bench for blink_scheduler at DIV=4: directed scenarios plus random traffic,
// every cycle compared with a phase-arithmetic reference model.
module tb_blink_scheduler;
  import blink_pkg::*;

  localparam int REF = 20;
  localparam int HZ  = 5;
  localparam int DIV = 4;
  localparam int TW  = 16;
  localparam int CW  = 8;

  logic          clk_FPGA;
  logic          reset;
  logic          start;
  logic          stop;
  logic [TW-1:0] on_time;
  logic [TW-1:0] off_time;
  logic [CW-1:0] blink_count;
  logic          led_out;
  logic          busy;
  logic          done;
  logic          tick;
  state_t        state_dbg;

  int checks = 0;
  int errors = 0;

  // reference model: mode 0 idle, 1 running, 2 done cycle
  int m_mode = 0;
  int m_k    = 0;
  int m_on   = 1;
  int m_off  = 1;
  int m_cnt  = 0;
  int m_pk   = 0;

  int busy_n;
  int done_n;
  int tick_n;

  blink_scheduler #(
    .REFERENCE_CLOCK (REF),
    .TICK_HZ         (HZ),
    .TIME_W          (TW),
    .COUNT_W         (CW)
  ) dut (
    .clk_FPGA    (clk_FPGA),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .on_time     (on_time),
    .off_time    (off_time),
    .blink_count (blink_count),
    .led_out     (led_out),
    .busy        (busy),
    .done        (done),
    .tick        (tick),
    .state_dbg   (state_dbg)
  );

  initial clk_FPGA = 1'b0;
  always #5 clk_FPGA = ~clk_FPGA;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_edge(input logic s, input logic p, input logic r);
    bit accept;
    if (r) begin
      m_mode = 0;
      m_k    = 0;
      m_pk   = 0;
    end else begin
      accept = (m_mode == 0) && s && !p;
      m_pk   = accept ? 0 : (m_pk + 1) % DIV;
      case (m_mode)
        0: if (accept) begin
          m_mode = 1;
          m_k    = 0;
          m_on   = (on_time  == 0) ? 1 : int'(on_time);
          m_off  = (off_time == 0) ? 1 : int'(off_time);
          m_cnt  = int'(blink_count);
        end
        1: begin
          if (p) m_mode = 0;
          else begin
            m_k++;
            if (m_cnt != 0 && m_k == m_cnt * (m_on + m_off) * DIV) m_mode = 2;
          end
        end
        default: m_mode = 0;
      endcase
    end
  endtask

  task automatic check_outputs();
    logic   e_led;
    state_t e_state;
    e_led = (m_mode == 1) && ((m_k % ((m_on + m_off) * DIV)) < m_on * DIV);
    if (m_mode == 0)      e_state = IDLE;
    else if (m_mode == 2) e_state = DONE;
    else                  e_state = e_led ? ON : OFF;
    chk("led_out", 32'(led_out), 32'(e_led));
    chk("busy",    32'(busy),    32'(m_mode == 1));
    chk("done",    32'(done),    32'(m_mode == 2));
    chk("tick",    32'(tick),    32'(m_pk == DIV - 1));
    chk("state",   32'(state_dbg), 32'(e_state));
  endtask

  task automatic step(input logic s, input logic p, input logic r);
    start = s;
    stop  = p;
    reset = r;
    @(posedge clk_FPGA);
    model_edge(s, p, r);
    #1;
    check_outputs();
    busy_n += int'(busy);
    done_n += int'(done);
    tick_n += int'(tick);
  endtask

  task automatic set_cfg(input int on_v, input int off_v, input int cnt_v);
    on_time     = TW'(on_v);
    off_time    = TW'(off_v);
    blink_count = CW'(cnt_v);
  endtask

  task automatic clear_counts();
    busy_n = 0;
    done_n = 0;
    tick_n = 0;
  endtask

  initial begin
    start = 1'b0;
    stop  = 1'b0;
    reset = 1'b1;
    set_cfg(0, 0, 0);
    clear_counts();

    // 1: reset, then idle with free-running ticks
    repeat (3) step(0, 0, 1);
    clear_counts();
    repeat (8) step(0, 0, 0);
    chk("t1_tick_count", 32'(tick_n), 32'd2);
    chk("t1_busy_count", 32'(busy_n), 32'd0);

    // 2: 2/1 ticks, two blinks -> 24 busy cycles and one done pulse
    set_cfg(2, 1, 2);
    clear_counts();
    step(1, 0, 0);
    repeat (30) step(0, 0, 0);
    chk("t2_busy_cycles", 32'(busy_n), 32'd24);
    chk("t2_done_pulses", 32'(done_n), 32'd1);

    // 3: zero durations behave as one tick
    set_cfg(0, 0, 1);
    clear_counts();
    step(1, 0, 0);
    repeat (12) step(0, 0, 0);
    chk("t3_busy_cycles", 32'(busy_n), 32'd8);
    chk("t3_done_pulses", 32'(done_n), 32'd1);

    // 4: endless blinking aborted by stop
    set_cfg(1, 1, 0);
    clear_counts();
    step(1, 0, 0);
    repeat (50) step(0, 0, 0);
    step(0, 1, 0);
    chk("t4_led_after_stop",  32'(led_out), 32'd0);
    chk("t4_busy_after_stop", 32'(busy), 32'd0);
    repeat (6) step(0, 0, 0);
    chk("t4_done_pulses", 32'(done_n), 32'd0);

    // 5: restart mid-sequence ignored; start+stop in IDLE ignored
    set_cfg(2, 2, 1);
    clear_counts();
    step(1, 0, 0);
    repeat (5) step(0, 0, 0);
    set_cfg(5, 3, 4);
    step(1, 0, 0);
    repeat (20) step(0, 0, 0);
    chk("t5_busy_cycles", 32'(busy_n), 32'd16);
    step(1, 1, 0);
    chk("t5_start_stop_idle", 32'(state_dbg), 32'(IDLE));
    step(0, 0, 0);

    // 6: reset during OFF, then a full fresh 3-blink run
    set_cfg(1, 2, 3);
    clear_counts();
    step(1, 0, 0);
    repeat (6) step(0, 0, 0);
    chk("t6_in_off", 32'(state_dbg), 32'(OFF));
    step(0, 0, 1);
    chk("t6_reset_idle", 32'(state_dbg), 32'(IDLE));
    repeat (3) step(0, 0, 0);
    chk("t6_no_done", 32'(done_n), 32'd0);
    clear_counts();
    step(1, 0, 0);
    repeat (40) step(0, 0, 0);
    chk("t6_busy_cycles", 32'(busy_n), 32'd36);
    chk("t6_done_pulses", 32'(done_n), 32'd1);

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      set_cfg($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      step(($urandom_range(0, 7) == 0), ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 199) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
